stopwatch_main: RTL and testbench

STOPWATCH_MAIN -- requirements
Module: stopwatch_main

---
 rtl/stopwatch_pkg.sv | 91 +++++++++
 rtl/stopwatch_display.sv | 47 ++++
 rtl/stopwatch_main.sv | 123 ++++++++++++
 tb/tb_stopwatch_main.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: control states, sel modes,
// 7-segment digit patterns, count limits and BCD helper functions.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_UP_ZERO   = 2'b00;
  localparam logic [1:0] MODE_UP_LOAD   = 2'b01;
  localparam logic [1:0] MODE_DOWN_FULL = 2'b10;
  localparam logic [1:0] MODE_DOWN_LOAD = 2'b11;

  localparam logic [15:0] COUNT_MAX = 16'h9999;
  localparam logic [15:0] COUNT_MIN = 16'h0000;

  // Active-low segments, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] initial_count(input logic [1:0] sel, input logic [7:0] load);
    logic [15:0] v;
    case (sel)
      MODE_UP_ZERO:   v = COUNT_MIN;
      MODE_DOWN_FULL: v = COUNT_MAX;
      default:        v = {clamp_bcd(load[7:4]), clamp_bcd(load[3:0]), 8'h00};
    endcase
    return v;
  endfunction

  // +/-1 on a four-digit BCD value, rippling carry/borrow through every digit
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (up) begin
          if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed 7-segment driver: refresh counter, digit select and
// BCD decode. Scans D0..D3 continuously, each digit for REFRESH_CYCLES clocks.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  output logic [3:0]  an,
  output logic [6:0]  sseg
);

  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

  logic [31:0] refresh;
  logic [1:0]  digit_idx;
  logic [3:0]  digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh   <= '0;
      digit_idx <= '0;
    end else if (refresh == REFRESH_LAST) begin
      refresh   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      refresh <= refresh + 32'd1;
    end
  end

  always_comb begin
    digit = count[3:0];
    case (digit_idx)
      2'd0: digit = count[3:0];
      2'd1: digit = count[7:4];
      2'd2: digit = count[11:8];
      2'd3: digit = count[15:12];
      default: digit = count[3:0];
    endcase
  end

  assign an   = ~(4'b0001 << digit_idx);
  assign sseg = bcd_to_seg(digit);

endmodule

// File: rtl/stopwatch_main.sv
// Stopwatch top: P edge detect, control FSM, 0.01 s prescaler and BCD count.
// Optional STOPWATCH_DEBOUNCE_EN adds a synchronizer + debouncer on P.
module stopwatch_main
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYCLES     = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       R,
  input  logic       P,
  input  logic [7:0] load,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic [1:0] cstateDb
);

  if (TICK_CYCLES < 1 || REFRESH_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("stopwatch_main: cycle parameters must be >= 1");
  end

  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

  logic        p_in;
  logic        p_prev;
  logic        p_edge;
  state_t      state;
  logic [31:0] presc;
  logic [15:0] count;
  logic [15:0] init;
  logic [15:0] stepped;
  logic [15:0] limit;
  logic        up;
  logic        tick;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam logic [31:0] DEBOUNCE_LAST = 32'(DEBOUNCE_CYCLES - 1);
  logic [1:0]  p_sync;
  logic        p_stable;
  logic [31:0] db_cnt;

  always_ff @(posedge clk) begin
    if (R) begin
      p_sync   <= '0;
      p_stable <= 1'b0;
      db_cnt   <= '0;
    end else begin
      p_sync <= {p_sync[0], P};
      if (p_sync[1] == p_stable) db_cnt <= '0;
      else if (db_cnt == DEBOUNCE_LAST) begin
        p_stable <= p_sync[1];
        db_cnt   <= '0;
      end else db_cnt <= db_cnt + 32'd1;
    end
  end

  assign p_in = p_stable;
`else
  assign p_in = P;
`endif

  assign p_edge  = p_in & ~p_prev;
  assign init    = initial_count(sel, load);
  assign up      = ~sel[1];
  assign stepped = bcd_step(count, up);
  assign limit   = up ? COUNT_MAX : COUNT_MIN;
  assign tick    = (state == RUN) && (presc == TICK_LAST);

  // Reaching the limit wins over a simultaneous P edge, so RUN goes to DONE, not PAUSE
  always_ff @(posedge clk) begin
    if (R) begin
      state  <= IDLE;
      presc  <= '0;
      p_prev <= 1'b0;
      count  <= init;
    end else begin
      p_prev <= p_in;
      unique case (state)
        IDLE: begin
          count <= init;
          presc <= '0;
          if (p_edge) state <= RUN;
        end
        RUN: begin
          if (tick) begin
            presc <= '0;
            if (count == limit) state <= DONE;
            else begin
              count <= stepped;
              if (stepped == limit) state <= DONE;
              else if (p_edge)      state <= PAUSE;
            end
          end else if (p_edge) begin
            presc <= '0;
            state <= PAUSE;
          end else begin
            presc <= presc + 32'd1;
          end
        end
        PAUSE: begin
          presc <= '0;
          if (p_edge) state <= RUN;
        end
        DONE: presc <= '0;
      endcase
    end
  end

  assign cstateDb = state;

  stopwatch_display #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_display (
    .clk  (clk),
    .reset(R),
    .count(count),
    .an   (an),
    .sseg (sseg)
  );

endmodule

// File: tb/tb_stopwatch_main.sv
// Self-checking bench for stopwatch_main with an integer-hundredths reference model.
module tb_stopwatch_main;

  logic       clk = 1'b0;
  logic       R, P;
  logic [7:0] load;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [1:0] cstateDb;

  int checks = 0;
  int errors = 0;

  int   m_state;
  int   m_cnt;
  int   m_scan;
  logic m_pprev;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  always #5 clk = ~clk;

  stopwatch_main #(
    .TICK_CYCLES   (1),
    .REFRESH_CYCLES(2)
  ) dut (
    .clk     (clk),
    .R       (R),
    .P       (P),
    .load    (load),
    .sel     (sel),
    .an      (an),
    .sseg    (sseg),
    .cstateDb(cstateDb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int init_val(input logic [1:0] s, input logic [7:0] l);
    int t, o;
    t = (l[7:4] > 9) ? 9 : int'(l[7:4]);
    o = (l[3:0] > 9) ? 9 : int'(l[3:0]);
    if (!s[0]) return s[1] ? 9999 : 0;
    return (t * 10 + o) * 100;
  endfunction

  // One clock of the stopwatch rules, on hundredths held as a plain integer
  task automatic model_step();
    logic edge_p;
    if (R) begin
      m_state = 0;
      m_cnt   = init_val(sel, load);
      m_pprev = 1'b0;
      m_scan  = 0;
    end else begin
      edge_p  = P && !m_pprev;
      m_pprev = P;
      m_scan++;
      case (m_state)
        0: begin
          m_cnt = init_val(sel, load);
          if (edge_p) m_state = 1;
        end
        1: begin
          if (!sel[1]) begin
            if (m_cnt == 9999) m_state = 3;
            else begin
              m_cnt = m_cnt + 1;
              if (m_cnt == 9999) m_state = 3;
            end
          end else begin
            if (m_cnt == 0) m_state = 3;
            else begin
              m_cnt = m_cnt - 1;
              if (m_cnt == 0) m_state = 3;
            end
          end
          if (m_state == 1 && edge_p) m_state = 2;
        end
        2: if (edge_p) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    int         idx;
    int         dig;
    logic [3:0] exp_an;
    @(posedge clk);
    model_step();
    @(negedge clk);
    idx    = (m_scan / 2) % 4;
    dig    = (m_cnt / pow10[idx]) % 10;
    exp_an = ~(4'b0001 << idx);
    check("state", 32'(cstateDb), 32'(m_state));
    check("an", 32'(an), 32'(exp_an));
    check("sseg", 32'(sseg), 32'(seg_ref[dig]));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press();
    P = 1'b1;
    cycle();
    P = 1'b0;
  endtask

  // Rebuild the shown BCD value from one full scan of the display
  task automatic read_count(output logic [15:0] v);
    logic [3:0] sel_an;
    v = '0;
    repeat (8) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        sel_an = ~(4'b0001 << i);
        if (an == sel_an)
          for (int d = 0; d < 10; d++)
            if (sseg == seg_ref[d]) v[4*i +: 4] = 4'(d);
      end
    end
  endtask

  logic [15:0] shown;

  initial begin
    R = 1'b1; P = 1'b0; sel = 2'b00; load = 8'h00;
    m_state = 0; m_cnt = 0; m_scan = 0; m_pprev = 1'b0;

    // Reset, then count up 150 ticks from 00.00 and pause there
    run(20);
    check("rst_state", 32'(cstateDb), 32'h0);
    check("rst_an", 32'(an), 32'hE);
    check("rst_sseg", 32'(sseg), 32'h40);
    R = 1'b0;
    press();
    check("idle_to_run", 32'(cstateDb), 32'h1);
    run(149);
    press();
    check("pause_state", 32'(cstateDb), 32'h2);
    read_count(shown);
    check("count_0150", 32'(shown), 32'h0150);
    run(50);
    read_count(shown);
    check("pause_frozen", 32'(shown), 32'h0150);
    press();
    run(10);

    // Up from 99.00 to DONE at 99.99; P ignored afterwards
    sel = 2'b01; load = 8'h99; R = 1'b1;
    cycle();
    R = 1'b0;
    press();
    run(105);
    check("up_done", 32'(cstateDb), 32'h3);
    read_count(shown);
    check("up_hold", 32'(shown), 32'h9999);
    press();
    run(5);
    check("done_ignores_p", 32'(cstateDb), 32'h3);

    // Down from 01.00 to DONE at 00.00
    sel = 2'b11; load = 8'h01; R = 1'b1;
    cycle();
    R = 1'b0;
    press();
    run(102);
    check("down_done", 32'(cstateDb), 32'h3);
    read_count(shown);
    check("down_hold", 32'(shown), 32'h0000);
    sel = 2'b10; R = 1'b1;
    cycle();
    R = 1'b0;
    read_count(shown);
    check("init_9999", 32'(shown), 32'h9999);

    // Reset with a simultaneous P edge mid-RUN; clamped load
    sel = 2'b00; R = 1'b1;
    cycle();
    R = 1'b0;
    press();
    run(30);
    R = 1'b1; P = 1'b1;
    cycle();
    check("rst_over_p", 32'(cstateDb), 32'h0);
    P = 1'b0; sel = 2'b01; load = 8'hFA;
    cycle();
    R = 1'b0;
    read_count(shown);
    check("clamp_9900", 32'(shown), 32'h9900);

    // Display scan of 12.34
    sel = 2'b01; load = 8'h12; R = 1'b1;
    cycle();
    R = 1'b0;
    press();
    run(33);
    press();
    read_count(shown);
    check("disp_1234", 32'(shown), 32'h1234);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      R = ($urandom_range(0, 99) == 0);
      P = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) begin
        sel  = 2'($urandom);
        load = 8'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
